// File: rtl/mem_arb_ctrl_if.sv
// Client and memory-side signal bundle for mem_arb_ctrl.
// slave = controller view, master = client view, mem = memory macro view.
interface mem_arb_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 8
);
  logic          clr;
  logic          init_done;

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wd0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rd0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rd1;

  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_i;
  logic [DW-1:0] mem_d_o;

  modport slave (
    input  clr, req0, we0, addr0, wd0, req1, we1, addr1, wd1, mem_d_o,
    output init_done, gnt0, rvalid0, rd0, gnt1, rvalid1, rd1,
    output mem_wr, mem_addr, mem_d_i
  );

  modport master (
    output clr, req0, we0, addr0, wd0, req1, we1, addr1, wd1,
    input  init_done, gnt0, rvalid0, rd0, gnt1, rvalid1, rd1
  );

  modport mem (
    input  mem_wr, mem_addr, mem_d_i,
    output mem_d_o
  );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Two-port round-robin controller for a single-port synchronous memory.
// Sweeps every location to INIT_VAL after reset/clr; read data returns 1 cycle after grant.
module mem_arb_ctrl #(
  parameter int            AW       = 10,
  parameter int            DW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arb_ctrl_if.slave bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW-1:0] CNT_MAX = '1;

  state_t        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          last_q, last_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;

  logic          gnt0, gnt1;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_i;
  logic          init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      last_q     <= 1'b1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      last_q     <= last_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    last_d     = last_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_d_i    = '0;
    init_done  = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Reset leaves the state at INIT, so the write strobe must be held off while rst_n is low.
        mem_wr     = rst_n;
        mem_addr   = init_cnt_q;
        mem_d_i    = INIT_VAL;
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == CNT_MAX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (bus.clr) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end else begin
          gnt0 = bus.req0 & (~bus.req1 | last_q);
          gnt1 = bus.req1 & (~bus.req0 | ~last_q);
          if (gnt0) begin
            mem_wr   = bus.we0;
            mem_addr = bus.addr0;
            mem_d_i  = bus.wd0;
            last_d   = 1'b0;
          end else if (gnt1) begin
            mem_wr   = bus.we1;
            mem_addr = bus.addr1;
            mem_d_i  = bus.wd1;
            last_d   = 1'b1;
          end
        end
      end
    endcase

    rvalid0_d = gnt0 & ~bus.we0;
    rvalid1_d = gnt1 & ~bus.we1;
  end

  assign bus.init_done = init_done;
  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_d_i   = mem_d_i;
  assign bus.rvalid0   = rvalid0_q;
  assign bus.rvalid1   = rvalid1_q;
  assign bus.rd0       = rvalid0_q ? bus.mem_d_o : '0;
  assign bus.rd1       = rvalid1_q ? bus.mem_d_o : '0;

endmodule
